// File: rtl/batcharger_ctrl_if.sv
// Charger controller bus: ADC sample inputs, enable/capacity,
// phase flags and reference codes toward the analog core.
interface batcharger_ctrl_if;
  logic       en;
  logic [3:0] sel;
  logic       sample_valid;
  logic [7:0] vbat;
  logic [7:0] ibat;
  logic [7:0] vtemp;
  logic       tc;
  logic       cc;
  logic       cv;
  logic [7:0] iref;
  logic [7:0] vref;
  logic       done;
  logic       fault;
  logic [1:0] fault_code;

  modport master (
    output en, sel, sample_valid, vbat, ibat, vtemp,
    input  tc, cc, cv, iref, vref, done, fault, fault_code
  );

  modport slave (
    input  en, sel, sample_valid, vbat, ibat, vtemp,
    output tc, cc, cv, iref, vref, done, fault, fault_code
  );
endinterface

// File: rtl/batcharger_ctrl.sv
// Battery charge sequencer: IDLE/TC/CC/CV/DONE/FAULT with debounce,
// safety timers and registered phase/reference outputs.
module batcharger_ctrl #(
  parameter logic [7:0]  VCUTOFF = 8'd128,
  parameter logic [7:0]  VFLOAT  = 8'd214,
  parameter logic [7:0]  VRECH   = 8'd204,
  parameter logic [7:0]  TMIN    = 8'd40,
  parameter logic [7:0]  TMAX    = 8'd200,
  parameter logic [3:0]  DEB     = 4'd3,
  parameter logic [15:0] TC_MAX  = 16'd1000,
  parameter logic [15:0] CV_MAX  = 16'd4000
) (
  input  logic               clk,
  input  logic               rstz,
  batcharger_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_TC, S_CC, S_CV, S_DONE, S_FAULT
  } state_t;

  state_t      state_q, state_d, nxt;
  logic [4:0]  cap_q, cap_d;
  logic [3:0]  deb_q, deb_d, deb_inc;
  logic [15:0] tmr_q, tmr_d;
  logic [1:0]  code_q, code_d;
  logic        temp_ok, chg, qual;
  logic [7:0]  iref_d;

  logic        tc_q, cc_q, cv_q, done_q, fault_q;
  logic [7:0]  iref_q, vref_q;
  logic [1:0]  fcode_q;

  assign temp_ok = (bus.vtemp >= TMIN) && (bus.vtemp <= TMAX);
  assign chg     = state_q inside {S_TC, S_CC, S_CV, S_DONE};
  assign deb_inc = (deb_q == 4'hF) ? deb_q : deb_q + 4'd1;

  // Per-phase qualifying condition and its debounced destination
  always_comb begin
    qual = 1'b0;
    nxt  = state_q;
    unique case (state_q)
      S_TC: begin
        qual = bus.vbat >= VCUTOFF;
        nxt  = S_CC;
      end
      S_CC: begin
        qual = bus.vbat >= VFLOAT;
        nxt  = S_CV;
      end
      S_CV: begin
        qual = bus.ibat <= {3'b0, cap_q};
        nxt  = S_DONE;
      end
      S_DONE: begin
        qual = bus.vbat < VRECH;
        nxt  = S_CC;
      end
      S_FAULT: begin
        qual = (code_q == 2'b01) && temp_ok;
        nxt  = S_IDLE;
      end
      default: ;
    endcase
  end

  // Next state with priority en > temperature > timer > debounce
  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    deb_d   = deb_q;
    tmr_d   = tmr_q;
    code_d  = code_q;
    if (!bus.en) begin
      state_d = S_IDLE;
      deb_d   = '0;
      tmr_d   = '0;
      code_d  = '0;
    end else if (bus.sample_valid) begin
      tmr_d = (&tmr_q) ? tmr_q : tmr_q + 16'd1;
      deb_d = qual ? deb_inc : 4'd0;
      if (state_q == S_IDLE) begin
        if (temp_ok) begin
          state_d = (bus.vbat < VCUTOFF) ? S_TC : S_CC;
          cap_d   = {1'b0, bus.sel} + 5'd1;
        end
      end else if (chg && !temp_ok) begin
        state_d = S_FAULT;
        code_d  = 2'b01;
      end else if (state_q == S_TC && tmr_d >= TC_MAX) begin
        state_d = S_FAULT;
        code_d  = 2'b10;
      end else if (state_q == S_CV && tmr_d >= CV_MAX) begin
        state_d = S_DONE;
      end else if (qual && deb_inc >= DEB) begin
        state_d = nxt;
      end
      if (state_d != state_q) begin
        deb_d = '0;
        tmr_d = '0;
      end
    end
  end

  // Current reference for the phase being entered
  always_comb begin
    iref_d = '0;
    unique case (state_d)
      S_TC:       iref_d = {3'b0, cap_d};
      S_CC, S_CV: iref_d = {3'b0, cap_d} * 8'd10;
      default:    iref_d = '0;
    endcase
  end

  // State, counters and outputs all registered from the next state
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q <= S_IDLE;
      cap_q   <= '0;
      deb_q   <= '0;
      tmr_q   <= '0;
      code_q  <= '0;
      tc_q    <= 1'b0;
      cc_q    <= 1'b0;
      cv_q    <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      iref_q  <= '0;
      vref_q  <= '0;
      fcode_q <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      deb_q   <= deb_d;
      tmr_q   <= tmr_d;
      code_q  <= code_d;
      tc_q    <= state_d == S_TC;
      cc_q    <= state_d == S_CC;
      cv_q    <= state_d == S_CV;
      done_q  <= state_d == S_DONE;
      fault_q <= state_d == S_FAULT;
      iref_q  <= iref_d;
      vref_q  <= (state_d == S_CV) ? VFLOAT : 8'd0;
      fcode_q <= (state_d == S_FAULT) ? code_d : 2'b00;
    end
  end

  assign bus.tc         = tc_q;
  assign bus.cc         = cc_q;
  assign bus.cv         = cv_q;
  assign bus.done       = done_q;
  assign bus.fault      = fault_q;
  assign bus.iref       = iref_q;
  assign bus.vref       = vref_q;
  assign bus.fault_code = fcode_q;

endmodule

// File: tb/tb_batcharger_ctrl.sv
// Bench for batcharger_ctrl: directed charge scenarios plus random
// samples, every cycle compared to a phase-level reference model.
module tb_batcharger_ctrl;

  logic clk;
  logic rstz;
  int   n_tests;
  int   n_fail;

  batcharger_ctrl_if b ();

  batcharger_ctrl dut (
    .clk  (clk),
    .rstz (rstz),
    .bus  (b.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: phase, latched capacity, consecutive-qualifying
  // run length, samples spent in the phase, fault reason.
  localparam int IDLE = 0;
  localparam int TC   = 1;
  localparam int CC   = 2;
  localparam int CV   = 3;
  localparam int DONE = 4;
  localparam int FLT  = 5;

  int m_ph, m_cap, m_run, m_age, m_code;

  function automatic int after_deb(input int ph);
    case (ph)
      TC:      return CC;
      CC:      return CV;
      CV:      return DONE;
      DONE:    return CC;
      default: return IDLE;
    endcase
  endfunction

  task automatic model_sample();
    int  nx;
    bit  tok;
    bit  q;
    tok = (b.vtemp >= 40) && (b.vtemp <= 200);
    nx  = m_ph;
    q   = 1'b0;
    if (m_age < 65535) m_age++;
    case (m_ph)
      TC:   q = b.vbat >= 128;
      CC:   q = b.vbat >= 214;
      CV:   q = int'(b.ibat) <= m_cap;
      DONE: q = b.vbat < 204;
      FLT:  q = (m_code == 1) && tok;
      default: q = 1'b0;
    endcase
    m_run = q ? m_run + 1 : 0;
    if (m_ph == IDLE) begin
      if (tok) begin
        nx    = (b.vbat < 128) ? TC : CC;
        m_cap = int'(b.sel) + 1;
      end
    end else if (m_ph != FLT && !tok) begin
      nx = FLT;
      m_code = 1;
    end else if (m_ph == TC && m_age >= 1000) begin
      nx = FLT;
      m_code = 2;
    end else if (m_ph == CV && m_age >= 4000) begin
      nx = DONE;
    end else if (q && m_run >= 3) begin
      nx = after_deb(m_ph);
    end
    if (nx != m_ph) begin
      m_run = 0;
      m_age = 0;
    end
    m_ph = nx;
  endtask

  always @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      m_ph = IDLE; m_cap = 0; m_run = 0; m_age = 0; m_code = 0;
    end else if (!b.en) begin
      m_ph = IDLE; m_run = 0; m_age = 0; m_code = 0;
    end else if (b.sample_valid) begin
      model_sample();
    end
  end

  function automatic logic [22:0] model_out();
    logic [7:0] ir;
    logic [7:0] vr;
    logic [1:0] fc;
    ir = 8'd0;
    if (m_ph == TC) ir = 8'(m_cap);
    if (m_ph == CC || m_ph == CV) ir = 8'(m_cap * 10);
    vr = (m_ph == CV) ? 8'd214 : 8'd0;
    fc = (m_ph == FLT) ? 2'(m_code) : 2'd0;
    return {m_ph == TC, m_ph == CC, m_ph == CV, ir, vr,
            m_ph == DONE, m_ph == FLT, fc};
  endfunction

  function automatic logic [22:0] dut_out();
    return {b.tc, b.cc, b.cv, b.iref, b.vref, b.done, b.fault, b.fault_code};
  endfunction

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    logic [22:0] g;
    logic [22:0] e;
    g = dut_out();
    e = model_out();
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL model t=%0t got=%h exp=%h", $time, g, e);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic smp(input logic [7:0] v, input logic [7:0] i,
                     input logic [7:0] t);
    @(negedge clk);
    b.sample_valid = 1'b1;
    b.vbat  = v;
    b.ibat  = i;
    b.vtemp = t;
    @(posedge clk);
    #1 b.sample_valid = 1'b0;
  endtask

  task automatic en_off();
    @(negedge clk);
    b.en = 1'b0;
    @(posedge clk);
    #1;
    chk("en_off_idle", 32'(dut_out()), 32'd0);
    b.en = 1'b1;
  endtask

  initial begin
    logic [7:0] v;
    n_tests = 0;
    n_fail  = 0;
    rstz = 1'b1;
    b.en = 1'b0;
    b.sel = 4'd0;
    b.sample_valid = 1'b0;
    b.vbat = 8'd0;
    b.ibat = 8'd0;
    b.vtemp = 8'd100;
    #1 rstz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(dut_out()), 32'd0);
    @(negedge clk);
    rstz = 1'b1;
    b.en = 1'b1;
    b.sel = 4'b1000;

    // Trickle entry and debounced exit
    smp(8'd100, 8'd0, 8'd100);
    chk("tc_flag", 32'(b.tc), 32'd1);
    chk("tc_iref", 32'(b.iref), 32'd9);
    smp(8'd130, 8'd0, 8'd100);
    smp(8'd130, 8'd0, 8'd100);
    smp(8'd120, 8'd0, 8'd100);
    smp(8'd130, 8'd0, 8'd100);
    chk("tc_glitch_hold", 32'(b.tc), 32'd1);
    smp(8'd120, 8'd0, 8'd100);
    smp(8'd130, 8'd0, 8'd100);
    smp(8'd130, 8'd0, 8'd100);
    chk("tc_two_only", 32'(b.tc), 32'd1);
    smp(8'd130, 8'd0, 8'd100);
    chk("cc_flag", 32'(b.cc), 32'd1);
    chk("cc_iref", 32'(b.iref), 32'd90);

    // CC -> CV -> DONE -> CC
    repeat (3) smp(8'd214, 8'd100, 8'd100);
    chk("cv_flag", 32'(b.cv), 32'd1);
    chk("cv_iref", 32'(b.iref), 32'd90);
    chk("cv_vref", 32'(b.vref), 32'd214);
    repeat (3) smp(8'd214, 8'd9, 8'd100);
    chk("done_flag", 32'(b.done), 32'd1);
    chk("done_iref", 32'(b.iref), 32'd0);
    chk("done_vref", 32'(b.vref), 32'd0);
    repeat (3) smp(8'd203, 8'd50, 8'd100);
    chk("rech_cc", 32'(b.cc), 32'd1);
    chk("rech_iref", 32'(b.iref), 32'd90);
    b.sel = 4'b0000;
    smp(8'd150, 8'd100, 8'd100);
    chk("sel_ignored", 32'(b.iref), 32'd90);

    // Temperature fault and recovery
    smp(8'd150, 8'd100, 8'd210);
    chk("tfault_flag", 32'(b.fault), 32'd1);
    chk("tfault_code", 32'(b.fault_code), 32'd1);
    chk("tfault_cc", 32'(b.cc), 32'd0);
    repeat (3) smp(8'd150, 8'd100, 8'd100);
    chk("tfault_idle", 32'(dut_out()), 32'd0);
    smp(8'd150, 8'd100, 8'd100);
    chk("reenter_cc", 32'(b.cc), 32'd1);
    chk("reenter_iref", 32'(b.iref), 32'd10);

    // Trickle timer fault
    en_off();
    b.sel = 4'b1000;
    smp(8'd100, 8'd0, 8'd100);
    repeat (999) smp(8'd100, 8'd0, 8'd100);
    chk("tc_999", 32'(b.tc), 32'd1);
    smp(8'd100, 8'd0, 8'd100);
    chk("tmr_fault", 32'(b.fault), 32'd1);
    chk("tmr_code", 32'(b.fault_code), 32'd2);
    repeat (5) smp(8'd100, 8'd0, 8'd100);
    chk("tmr_latched", 32'(b.fault_code), 32'd2);
    en_off();

    // Async reset in CV, then CV timeout
    smp(8'd150, 8'd50, 8'd100);
    repeat (3) smp(8'd214, 8'd50, 8'd100);
    chk("cv_again", 32'(b.cv), 32'd1);
    @(negedge clk);
    #2 rstz = 1'b0;
    #1 chk("async_reset", 32'(dut_out()), 32'd0);
    #1 rstz = 1'b1;
    smp(8'd150, 8'd50, 8'd100);
    repeat (3) smp(8'd214, 8'd50, 8'd100);
    repeat (3999) smp(8'd214, 8'd50, 8'd100);
    chk("cv_3999", 32'(b.cv), 32'd1);
    smp(8'd214, 8'd50, 8'd100);
    chk("cv_timeout", 32'(b.done), 32'd1);

    // Randomised traffic checked by the model
    v = 8'd100;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      b.en = ($urandom_range(0, 199) != 0);
      b.sample_valid = ($urandom_range(0, 9) < 7);
      b.sel = 4'($urandom_range(0, 15));
      v = v + 8'($urandom_range(0, 6)) - 8'd2;
      if (v > 8'd235 || v < 8'd90) v = 8'd190;
      b.vbat = v;
      b.ibat = 8'($urandom_range(0, 30));
      case ($urandom_range(0, 59))
        0: b.vtemp = 8'd39;
        1: b.vtemp = 8'd201;
        2: b.vtemp = 8'd40;
        3: b.vtemp = 8'd200;
        default: b.vtemp = 8'($urandom_range(41, 199));
      endcase
    end
    @(negedge clk);
    b.sample_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/batcharger_ctrl.md
# batcharger_ctrl

Digital charge-sequencing controller for the 64b battery charger. It consumes periodic 8-bit ADC samples of battery voltage, charge current and battery temperature, and sequences the charger through trickle (TC), constant-current (CC) and constant-voltage (CV) phases. It drives the one-hot phase flags and the current/voltage reference codes that configure the analog charger core, and supervises temperature and safety timers.

## Interface
- VCUTOFF, 8'd128, vbat code: TC→CC threshold
- VFLOAT, 8'd214, vbat code: CC→CV threshold and CV regulation target
- VRECH, 8'd204, vbat code: DONE→CC recharge threshold
- TMIN, 8'd40, lowest allowed vtemp code (inclusive)
- TMAX, 8'd200, highest allowed vtemp code (inclusive)
- DEB, 3, consecutive qualifying samples needed for a debounced transition (1..15)
- TC_MAX, 16'd1000, max samples in TC before timer fault
- CV_MAX, 16'd4000, max samples in CV before forced DONE

- clk  in  1  system clock, rising edge
- rstz  in  1  asynchronous active-low reset
- en  in  1  charger enable
- sel  in  4  capacity select; cap = sel+1 in 50 mAh units (50..800 mAh)
- sample_valid  in  1  one-cycle strobe: vbat/ibat/vtemp are valid this cycle
- vbat  in  8  battery voltage code
- ibat  in  8  charge current code, LSB 5 mA
- vtemp  in  8  battery temperature code
- tc, cc, cv  out  1 each  one-hot phase flags (all 0 outside charging)
- iref  out  8  current reference code, LSB 5 mA
- vref  out  8  voltage reference code
- done  out  1  charge complete
- fault  out  1  fault active
- fault_code  out  2  01 temperature, 10 TC timer, 00 none

## Operation
- States: IDLE, TC, CC, CV, DONE, FAULT. Evaluation only on clock edges with sample_valid=1, except en and reset.
- cap_q latched from sel (cap = sel+1, 5 bits) on the IDLE→TC/CC transition; sel changes while charging are ignored.
- Derived codes: itc = cap_q (0.1C), icc = 10*cap_q (1C, max 160), iterm = cap_q. All 8-bit, no overflow possible.
- temp_ok = TMIN ≤ vtemp ≤ TMAX.
- en=0: next edge → IDLE from any state, counters and fault_code cleared. Priority: reset > en=0 > temperature > timer > debounced transitions.
- IDLE (en=1, sample, temp_ok): vbat < VCUTOFF → TC, else → CC. No debounce.
- TC: vbat ≥ VCUTOFF for DEB consecutive samples → CC; tmr reaching TC_MAX → FAULT, code 10.
- CC: vbat ≥ VFLOAT for DEB → CV.
- CV: ibat ≤ iterm for DEB → DONE; tmr reaching CV_MAX → DONE.
- DONE: vbat < VRECH for DEB → CC (cap_q retained).
- TC/CC/CV/DONE: any sample with !temp_ok → FAULT, code 01, immediately (no debounce).
- FAULT code 01: temp_ok for DEB → IDLE. FAULT code 10: latched until en=0.
- Debounce counter (4b) clears on any non-qualifying sample and on every state change. tmr (16b) counts samples in current state, clears on state change, saturates.
- Outputs per state: TC: tc=1, iref=itc. CC: cc=1, iref=icc. CV: cv=1, iref=icc, vref=VFLOAT. DONE: done=1. FAULT: fault=1. Unlisted outputs 0.

## Timing
- All outputs registered. A transition decided on the sample at edge k is visible on all outputs immediately after edge k (zero added latency).
- en=0 sampled at edge k → IDLE outputs after edge k.
- rstz low: state IDLE, all outputs 0, cap_q/counters 0, asynchronously; leaving reset needs a sample to start.
- sample_valid asserted on consecutive cycles: each cycle is an independent sample.
- DEB-th qualifying sample and a temperature fault on the same sample: FAULT wins.

## Test plan
- sel=4'b1000, en=1, samples vbat=100 vtemp=100 → TC, iref=9; three samples vbat=130 → CC, iref=90 after third; pattern 130,130,120,130 → stays TC.
- From CC, three samples vbat=214 → CV, iref=90, vref=214; three samples ibat=9 → DONE, done=1, iref=0, vref=0.
- From DONE, three samples vbat=203 → CC, iref=90; sel changed to 4'b0000 mid-CC → iref remains 90.
- TC held at vbat=100 for 1000 samples → fault=1, fault_code=10; vtemp normal samples do not clear it; en=0 → IDLE next edge.
- In CC, one sample vtemp=210 → fault=1, code 01, cc=0; three samples vtemp=100 → IDLE; next sample vbat=150 → CC.
- rstz pulsed low mid-CV (between edges) → all outputs 0 before next edge; CV held 4000 samples with ibat=50 → DONE.
